// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: frame constants and reader/parser state encodings for the UART command parser
package uart_cmd_pkg;
  localparam logic [7:0] UART_HDR = 8'hAA;
  localparam logic [7:0] CMD_LED = 8'h01;
  localparam logic [7:0] CMD_VALUE = 8'h02;
  typedef enum logic {RD_IDLE, RD_WAIT} rd_state_t;
  typedef enum logic [2:0] {P_HDR, P_CMD, P_DH, P_DL, P_CHK} p_state_t;
endpackage

// File: rtl/uart_fifo_cmd_parser_if.sv
// uart_fifo_cmd_parser_if: RX FIFO read port; master drives fifo_rx_clk/fifo_rx_req, slave drives fifo_rx_empty/fifo_rx_data
interface uart_fifo_cmd_parser_if;
  logic fifo_rx_clk;
  logic fifo_rx_empty;
  logic fifo_rx_req;
  logic [7:0] fifo_rx_data;
  modport master(output fifo_rx_clk, fifo_rx_req, input fifo_rx_empty, fifo_rx_data);
  modport slave(input fifo_rx_clk, fifo_rx_req, output fifo_rx_empty, fifo_rx_data);
endinterface

// File: rtl/uart_fifo_reader.sv
// uart_fifo_reader: pulses fifo_rx_req when data is waiting and flags byte_valid while the read data (rx_byte) is on the bus
module uart_fifo_reader import uart_cmd_pkg::*; (
  input  logic                          clk_50m,
  input  logic                          reset,
  uart_fifo_cmd_parser_if.master        fifo,
  output logic                          byte_valid,
  output logic [7:0]                    rx_byte
);
  rd_state_t st;
  logic go;
  assign fifo.fifo_rx_clk = clk_50m;
  assign rx_byte = fifo.fifo_rx_data;
  assign go = st == RD_IDLE && !fifo.fifo_rx_empty;
  always_ff @(posedge clk_50m)
    if (reset) begin
      st <= RD_IDLE;
      fifo.fifo_rx_req <= 1'b0;
      byte_valid <= 1'b0;
    end else begin
      st <= go ? RD_WAIT : RD_IDLE;
      fifo.fifo_rx_req <= go;
      byte_valid <= st == RD_WAIT;
    end
endmodule

// File: rtl/uart_fifo_cmd_parser.sv
// uart_fifo_cmd_parser: decodes AA/cmd/dh/dl/xor frames from the RX FIFO (fifo) into led, value, cmd_valid, frame_err, err_count
module uart_fifo_cmd_parser import uart_cmd_pkg::*; #(
  parameter logic [31:0] CLK_FREQ = 32'd50_000_000,
  parameter logic [31:0] TIMEOUT_MS = 32'd1
) (
  input  logic                   clk_50m,
  input  logic                   reset,
  uart_fifo_cmd_parser_if.master fifo,
  output logic [5:0]             led,
  output logic [15:0]            value,
  output logic                   cmd_valid,
  output logic                   frame_err,
  output logic [7:0]             err_count
);
  localparam logic [31:0] TIMEOUT_CYCLES = CLK_FREQ / 32'd1000 * TIMEOUT_MS;
  p_state_t st;
  logic byte_valid, timeout, last, ok, err;
  logic [7:0] rx_byte, cmd, dh, dl;
  logic [31:0] cnt;
  uart_fifo_reader u_reader (
    .clk_50m(clk_50m),
    .reset(reset),
    .fifo(fifo),
    .byte_valid(byte_valid),
    .rx_byte(rx_byte)
  );
  always_comb begin
    timeout = st != P_HDR && !byte_valid && cnt == TIMEOUT_CYCLES - 32'd2;
    last = byte_valid && st == P_CHK;
    ok = last && rx_byte == (cmd ^ dh ^ dl) && (cmd == CMD_LED || cmd == CMD_VALUE);
    err = timeout || (last && !ok);
  end
  always_ff @(posedge clk_50m)
    if (reset) begin
      st <= P_HDR;
      cmd <= 8'h00;
      dh <= 8'h00;
      dl <= 8'h00;
      cnt <= 32'd0;
      led <= 6'h00;
      value <= 16'h0000;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      err_count <= 8'h00;
    end else begin
      cmd_valid <= ok;
      frame_err <= err;
      if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (ok && cmd == CMD_LED) led <= dl[5:0];
      if (ok && cmd == CMD_VALUE) value <= {dh, dl};
      if (byte_valid && st == P_CMD) cmd <= rx_byte;
      if (byte_valid && st == P_DH) dh <= rx_byte;
      if (byte_valid && st == P_DL) dl <= rx_byte;
      cnt <= byte_valid || timeout || st == P_HDR ? 32'd0 : cnt + 32'd1;
      if (timeout) st <= P_HDR;
      else if (byte_valid)
        st <= st == P_HDR ? (rx_byte == UART_HDR ? P_CMD : P_HDR) :
              st == P_CHK ? P_HDR : p_state_t'(st + 3'd1);
    end
endmodule
